// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore main FSM that sequences lw/sw/R-type/beq/addi/j,
// plus the combinational ALU decoder. pcen is the only output with a combinational path from zero.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t ctrlFor(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t nextFor(input state_t s, input logic [5:0] o);
    state_t n;
    n = FETCH;
    case (s)
      FETCH: n = DECODE;
      DECODE: begin
        case (o)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXECUTE;
          OP_BEQ:       n = BRANCH;
          OP_ADDI:      n = ADDIEXEC;
          OP_J:         n = JUMP;
          default:      n = FETCH;
        endcase
      end
      MEMADR:   n = (o == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    n = MEMWB;
      EXECUTE:  n = ALUWB;
      ADDIEXEC: n = ADDIWB;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = nextFor(state_q, op);
  end

  // Outputs are registered from the next state, so they line up with state_q without decode delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrlFor(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrlFor(state_d);
    end
  end

  always_comb begin
    alucontrol = 3'b010;
    case (ctrl_q.aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
  end

  // Write enables are gated by reset so an asserted reset silences them immediately.
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign iord     = ctrl_q.iord;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign pcsrc    = ctrl_q.pcsrc;
  assign irwrite  = ctrl_q.irwrite  & ~reset;
  assign memwrite = ctrl_q.memwrite & ~reset;
  assign regwrite = ctrl_q.regwrite & ~reset;
  assign pcen     = (ctrl_q.pcwrite | (ctrl_q.branch & zero)) & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table-driven instruction vectors,
// directed reset sequences, and randomized instructions against an instruction-level model.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // {alucontrol, alusrca, alusrcb, iord, irwrite, memwrite, regdst, memtoreg, regwrite, pcsrc, pcen}
  localparam logic [14:0] RESET_OUTS = 15'b010_0_01_0_0_0_0_0_0_00_0;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
    .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .pcsrc(pcsrc), .pcen(pcen), .state(state)
  );

  logic [14:0] outs;
  assign outs = {alucontrol, alusrca, alusrcb, iord, irwrite, memwrite,
                 regdst, memtoreg, regwrite, pcsrc, pcen};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cpi;
  } vec_t;

  function automatic logic [2:0] rtypeAlu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Instruction-level model: which steps an opcode walks through.
  function automatic int pathLen(input logic [5:0] o);
    case (o)
      OP_LW:                     return 5;
      OP_SW, OP_RTYPE, OP_ADDI:  return 4;
      OP_BEQ, OP_J:              return 3;
      default:                   return 2;
    endcase
  endfunction

  function automatic int pathState(input logic [5:0] o, input int k);
    int p[5];
    p = '{0, 1, 0, 0, 0};
    case (o)
      OP_LW:    p = '{0, 1, 2, 3, 4};
      OP_SW:    p = '{0, 1, 2, 5, 0};
      OP_RTYPE: p = '{0, 1, 6, 7, 0};
      OP_ADDI:  p = '{0, 1, 9, 10, 0};
      OP_BEQ:   p = '{0, 1, 8, 0, 0};
      OP_J:     p = '{0, 1, 11, 0, 0};
      default:  p = '{0, 1, 0, 0, 0};
    endcase
    return p[k];
  endfunction

  function automatic logic [14:0] expOut(input int st, input logic [5:0] f, input logic z);
    logic [2:0] ac;
    logic       a, io, ir, mw, rd, mr, rw, pe;
    logic [1:0] b, ps;
    ac = 3'b010; a = 0; b = 2'b00; io = 0; ir = 0; mw = 0;
    rd = 0; mr = 0; rw = 0; ps = 2'b00; pe = 0;
    case (st)
      0:  begin b = 2'b01; ir = 1; pe = 1; end
      1:  b = 2'b11;
      2:  begin a = 1; b = 2'b10; end
      3:  io = 1;
      4:  begin mr = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin a = 1; ac = rtypeAlu(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin a = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      9:  begin a = 1; b = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {ac, a, b, io, ir, mw, rd, mr, rw, ps, pe};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one instruction starting in FETCH, called 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input bit randZero);
    int st;
    op = o;
    funct = f;
    zero = z;
    for (int k = 0; k < pathLen(o); k++) begin
      if (randZero) zero = 1'($urandom_range(0, 1));
      #1;
      st = pathState(o, k);
      checkOutput("state", 32'(state), 32'(st));
      checkOutput("outputs", 32'(outs), 32'(expOut(st, f, zero)));
      @(posedge clk);
      #1;
    end
    checkOutput("back_to_fetch", 32'(state), 32'd0);
  endtask

  task automatic measureCpi(input string name, input int expCpi);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state != 4'd0 && n < 10);
    checkOutput({"cpi_", name}, 32'(n), 32'(expCpi));
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"lw",        OP_LW,    6'b000000, 1'b0, 5};
    vecs[1]  = '{"sw",        OP_SW,    6'b000000, 1'b0, 4};
    vecs[2]  = '{"r_slt",     OP_RTYPE, 6'b101010, 1'b0, 4};
    vecs[3]  = '{"r_or",      OP_RTYPE, 6'b100101, 1'b0, 4};
    vecs[4]  = '{"r_add",     OP_RTYPE, 6'b100000, 1'b1, 4};
    vecs[5]  = '{"r_sub",     OP_RTYPE, 6'b100010, 1'b0, 4};
    vecs[6]  = '{"r_and",     OP_RTYPE, 6'b100100, 1'b0, 4};
    vecs[7]  = '{"r_badfn",   OP_RTYPE, 6'b111000, 1'b0, 4};
    vecs[8]  = '{"addi",      OP_ADDI,  6'b000000, 1'b0, 4};
    vecs[9]  = '{"beq_taken", OP_BEQ,   6'b000000, 1'b1, 3};
    vecs[10] = '{"beq_not",   OP_BEQ,   6'b000000, 1'b0, 3};
    vecs[11] = '{"j",         OP_J,     6'b000000, 1'b0, 3};
    vecs[12] = '{"illegal",   6'b111111, 6'b000000, 1'b1, 2};

    reset = 1'b1;
    op = 6'b111111;
    funct = 6'b000000;
    zero = 1'b1;
    #3;
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_outs", 32'(outs), 32'(RESET_OUTS));
    @(posedge clk);
    #1;
    checkOutput("reset_held_state", 32'(state), 32'd0);
    checkOutput("reset_held_outs", 32'(outs), 32'(RESET_OUTS));

    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("release_irwrite", 32'(irwrite), 32'd1);
    checkOutput("release_pcen", 32'(pcen), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("first_edge_decode", 32'(state), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("illegal_to_fetch", 32'(state), 32'd0);

    foreach (vecs[i]) begin
      op = vecs[i].op;
      funct = vecs[i].funct;
      zero = vecs[i].zero;
      measureCpi(vecs[i].name, vecs[i].cpi);
      applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].zero, 1'b0);
    end

    // Reset asserted mid-cycle while a store is writing memory.
    op = OP_SW;
    zero = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("memwr_state", 32'(state), 32'd5);
    checkOutput("memwr_memwrite", 32'(memwrite), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_state", 32'(state), 32'd0);
    checkOutput("async_reset_memwrite", 32'(memwrite), 32'd0);
    checkOutput("async_reset_outs", 32'(outs), 32'(RESET_OUTS));
    @(posedge clk);
    #1;
    checkOutput("async_reset_held", 32'(outs), 32'(RESET_OUTS));
    @(negedge clk);
    op = 6'b111111;
    reset = 1'b0;
    #1;
    checkOutput("rerelease_irwrite", 32'(irwrite), 32'd1);
    checkOutput("rerelease_pcen", 32'(pcen), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rerelease_decode", 32'(state), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rerelease_fetch", 32'(state), 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] o, f;
      case ($urandom_range(0, 7))
        0: o = OP_LW;
        1: o = OP_SW;
        2: o = OP_RTYPE;
        3: o = OP_BEQ;
        4: o = OP_ADDI;
        5: o = OP_J;
        default: o = 6'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 4))
          0: f = 6'b100000;
          1: f = 6'b100010;
          2: f = 6'b100100;
          3: f = 6'b100101;
          default: f = 6'b101010;
        endcase
      end else begin
        f = 6'($urandom);
      end
      applyStimulus(o, f, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
